// File: rtl/ram_stream_reader.sv
// Paced sequential reader: walks a window of a sync-read RAM and streams each word out on valid/ready.
// Latency: start edge -> READ -> LATCH -> out_valid; handshake -> TICK_DIV pace cycles -> READ -> LATCH -> out_valid.
// Backpressure: out_valid/out_data hold in SEND until out_ready; stop aborts from any busy state.
// Option: define RAM_STREAM_NUL_STOP_EN to treat a zero word read from RAM as an end-of-stream terminator.
module ram_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int TICK_DIV  = 262144
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic [ADDR_BITS-1:0] raddr,
    input  logic [WIDTH-1:0]     rdata,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_PACE
    } state_t;

    // Pace counter runs 0..TICK_DIV-1; keep at least one bit so the build is legal with no pacing.
    localparam int PACE_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PACE_BITS-1:0] PACE_LAST = (TICK_DIV > 0) ? PACE_BITS'(TICK_DIV - 1) : '0;
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   ONE_WORD  = (ADDR_BITS + 1)'(1);
    localparam state_t AFTER_SEND = (TICK_DIV > 0) ? S_PACE : S_READ;

    state_t                 state, state_n;
    logic [ADDR_BITS-1:0]   addr, addr_n;
    logic [ADDR_BITS-1:0]   base_q, base_n;
    logic [ADDR_BITS:0]     len_q, len_n;
    logic                   loop_q, loop_n;
    logic [ADDR_BITS:0]     remaining, remaining_n;
    logic [PACE_BITS-1:0]   pace_cnt, pace_n;
    logic                   valid_n;
    logic [WIDTH-1:0]       data_n;
    logic                   done_n;
    logic [ADDR_BITS-1:0]   addr_inc;

    // The address register drives the RAM directly, so rdata is ready in LATCH.
    assign raddr = addr;
    assign busy  = (state != S_IDLE);

    // Next address with wrap at DEPTH-1 (DEPTH need not be a power of two).
    assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + ADDR_ONE;

    // Next-state and datapath decisions; stop overrides everything once busy.
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        base_n      = base_q;
        len_n       = len_q;
        loop_n      = loop_q;
        remaining_n = remaining;
        pace_n      = pace_cnt;
        valid_n     = out_valid;
        data_n      = out_data;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    base_n = base_addr;
                    len_n  = length;
                    loop_n = loop;
                    if (length == '0) begin
                        done_n = 1'b1;
                    end else begin
                        addr_n      = base_addr;
                        remaining_n = length;
                        state_n     = S_READ;
                    end
                end
            end
            S_READ: begin
                state_n = S_LATCH;
            end
            S_LATCH: begin
`ifdef RAM_STREAM_NUL_STOP_EN
                if (rdata == '0) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    data_n  = rdata;
                    valid_n = 1'b1;
                    state_n = S_SEND;
                end
`else
                data_n  = rdata;
                valid_n = 1'b1;
                state_n = S_SEND;
`endif
            end
            S_SEND: begin
                if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    pace_n  = '0;
                    if (remaining == ONE_WORD) begin
                        if (loop_q) begin
                            addr_n      = base_q;
                            remaining_n = len_q;
                            state_n     = AFTER_SEND;
                        end else begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        addr_n      = addr_inc;
                        remaining_n = remaining - ONE_WORD;
                        state_n     = AFTER_SEND;
                    end
                end
            end
            S_PACE: begin
                if (pace_cnt == PACE_LAST) begin
                    pace_n  = '0;
                    state_n = S_READ;
                end else begin
                    pace_n = pace_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                valid_n = 1'b0;
            end
        endcase

        // Abort: a word handshaken on this same edge is already consumed, so dropping valid is enough.
        if (stop && (state != S_IDLE)) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
            done_n  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            base_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            remaining <= '0;
            pace_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            base_q    <= base_n;
            len_q     <= len_n;
            loop_q    <= loop_n;
            remaining <= remaining_n;
            pace_cnt  <= pace_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            done      <= done_n;
        end
    end

endmodule
